bridge_router: RTL and testbench

- Sits between the single APF bridge master and up to NUM_SLAVES bridge slaves in the core; shares the bridge between them by address decode.
- Registers each master command, steers it to exactly one slave, and byte-swaps data for slaves flagged little-endian.
- Returns read data to the master at a fixed latency and counts accesses that match no slave.

---
 rtl/bridge_router.sv | 115 +++++++++++
 tb/tb_bridge_router.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bridge_router.sv
// Address-decoding bridge router: one master shared across NUM_SLAVES slaves, with per-slave byte swap.
// Strobes reach the slave 1 cycle after the master strobe; read data returns RD_LATENCY+1 cycles after m_rd.
module bridge_router #(
    parameter int                         NUM_SLAVES    = 4,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE    = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK    = {NUM_SLAVES{32'hF000_0000}},
    parameter logic [NUM_SLAVES-1:0]      SLAVE_LITTLE  = {NUM_SLAVES{1'b0}},
    parameter int                         RD_LATENCY    = 2,
    parameter logic [31:0]                UNMAPPED_DATA = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_addr,
    input  logic [31:0]                  m_wr_data,
    input  logic                         m_wr,
    input  logic                         m_rd,
    output logic [31:0]                  m_rd_data,
    output logic [32*NUM_SLAVES-1:0]     s_addr,
    output logic [32*NUM_SLAVES-1:0]     s_wr_data,
    output logic [NUM_SLAVES-1:0]        s_wr,
    output logic [NUM_SLAVES-1:0]        s_rd,
    input  logic [32*NUM_SLAVES-1:0]     s_rd_data,
    output logic [15:0]                  unmapped_count
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_oh;
    logic                  acc;
    logic                  rd_go;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_oh  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
        if (dec_hit) begin
            dec_oh[dec_idx] = 1'b1;
        end
    end

    assign acc   = m_wr | m_rd;
    assign rd_go = m_rd & ~m_wr;

    logic             sr_vld [RD_LATENCY];
    logic [IDX_W-1:0] sr_idx [RD_LATENCY];
    logic             sr_unm [RD_LATENCY];
    logic [31:0]      ret_data;

    always_comb begin
        ret_data = UNMAPPED_DATA;
        if (!sr_unm[RD_LATENCY-1]) begin
            ret_data = s_rd_data[32*32'(sr_idx[RD_LATENCY-1]) +: 32];
            if (SLAVE_LITTLE[sr_idx[RD_LATENCY-1]]) begin
                ret_data = swap32(ret_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_addr         <= '0;
            s_wr_data      <= '0;
            s_wr           <= '0;
            s_rd           <= '0;
            m_rd_data      <= '0;
            unmapped_count <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                sr_vld[k] <= 1'b0;
                sr_idx[k] <= '0;
                sr_unm[k] <= 1'b0;
            end
        end else begin
            s_wr <= (m_wr  && dec_hit) ? dec_oh : '0;
            s_rd <= (rd_go && dec_hit) ? dec_oh : '0;

            if (acc) begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    s_addr[32*i +: 32]    <= m_addr;
                    s_wr_data[32*i +: 32] <= SLAVE_LITTLE[i] ? swap32(m_wr_data) : m_wr_data;
                end
            end

            if (acc && !dec_hit && unmapped_count != 16'hFFFF) begin
                unmapped_count <= unmapped_count + 16'd1;
            end

            sr_vld[0] <= rd_go;
            sr_idx[0] <= dec_idx;
            sr_unm[0] <= ~dec_hit;
            for (int k = 1; k < RD_LATENCY; k++) begin
                sr_vld[k] <= sr_vld[k-1];
                sr_idx[k] <= sr_idx[k-1];
                sr_unm[k] <= sr_unm[k-1];
            end

            if (sr_vld[RD_LATENCY-1]) begin
                m_rd_data <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_bridge_router.sv
// Directed bench for bridge_router: decode, byte swap, read pipeline, unmapped counting, mid-run reset.
module tb_bridge_router;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  m_addr;
    logic [31:0]  m_wr_data;
    logic         m_wr;
    logic         m_rd;
    logic [31:0]  m_rd_data;
    logic [127:0] s_addr;
    logic [127:0] s_wr_data;
    logic [3:0]   s_wr;
    logic [3:0]   s_rd;
    logic [127:0] s_rd_data;
    logic [15:0]  unmapped_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bridge_router #(
        .NUM_SLAVES    (4),
        .SLAVE_BASE    ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK    ({4{32'hF000_0000}}),
        .SLAVE_LITTLE  (4'b0100),
        .RD_LATENCY    (2),
        .UNMAPPED_DATA (32'hBAD0_BAD0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m_addr         (m_addr),
        .m_wr_data      (m_wr_data),
        .m_wr           (m_wr),
        .m_rd           (m_rd),
        .m_rd_data      (m_rd_data),
        .s_addr         (s_addr),
        .s_wr_data      (s_wr_data),
        .s_wr           (s_wr),
        .s_rd           (s_rd),
        .s_rd_data      (s_rd_data),
        .unmapped_count (unmapped_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        m_addr    = 32'h0;
        m_wr_data = 32'h0;
        m_wr      = 1'b0;
        m_rd      = 1'b0;
        s_rd_data = '0;
        tick();
        tick();

        check("rst_s_wr",       {28'h0, s_wr}, 32'h0);
        check("rst_s_rd",       {28'h0, s_rd}, 32'h0);
        check("rst_s_addr1",    s_addr[63:32], 32'h0);
        check("rst_s_wdata2",   s_wr_data[95:64], 32'h0);
        check("rst_m_rd_data",  m_rd_data, 32'h0);
        check("rst_unmapped",   {16'h0, unmapped_count}, 32'h0);
        reset = 1'b0;

        // Write to slave 1
        m_addr = 32'h1000_0004; m_wr_data = 32'hA5A5_0001; m_wr = 1'b1;
        tick();
        m_wr = 1'b0;
        check("wr1_s_wr",       {28'h0, s_wr}, 32'h0000_0002);
        check("wr1_s_rd",       {28'h0, s_rd}, 32'h0);
        check("wr1_wdata1",     s_wr_data[63:32], 32'hA5A5_0001);
        check("wr1_addr1",      s_addr[63:32], 32'h1000_0004);
        check("wr1_addr3",      s_addr[127:96], 32'h1000_0004);
        tick();
        check("wr1_pulse_end",  {28'h0, s_wr}, 32'h0);

        // Write to little-endian slave 2
        m_addr = 32'h2000_0000; m_wr_data = 32'hDEAD_BEEF; m_wr = 1'b1;
        tick();
        m_wr = 1'b0;
        check("wr2_s_wr",       {28'h0, s_wr}, 32'h0000_0004);
        check("wr2_wdata2_swap", s_wr_data[95:64], 32'hEFBE_ADDE);
        check("wr2_wdata0_raw", s_wr_data[31:0], 32'hDEAD_BEEF);
        tick();

        // Read from little-endian slave 2
        s_rd_data[95:64] = 32'h1122_3344;
        m_addr = 32'h2000_0000; m_rd = 1'b1;
        tick();
        m_rd = 1'b0;
        check("rd2_s_rd",       {28'h0, s_rd}, 32'h0000_0004);
        tick();
        check("rd2_early",      m_rd_data, 32'h0);
        check("rd2_s_rd_end",   {28'h0, s_rd}, 32'h0);
        tick();
        check("rd2_data_swap",  m_rd_data, 32'h4433_2211);

        // Back-to-back reads to slaves 0..3
        s_rd_data = {32'h0000_0003, 32'h0200_0000, 32'h0000_0001, 32'h0000_0000};
        for (int k = 0; k < 4; k++) begin
            m_addr = 32'(k) << 28;
            m_rd   = 1'b1;
            tick();
            if (k >= 2) begin
                check($sformatf("b2b_data_%0d", k - 2), m_rd_data, 32'(k - 2));
            end
        end
        m_rd = 1'b0;
        tick();
        check("b2b_data_2",     m_rd_data, 32'h0000_0002);
        tick();
        check("b2b_data_3",     m_rd_data, 32'h0000_0003);

        // Simultaneous write and read: read ignored
        m_addr = 32'h0000_0010; m_wr_data = 32'h1234_5678; m_wr = 1'b1; m_rd = 1'b1;
        tick();
        m_wr = 1'b0; m_rd = 1'b0;
        check("simul_s_wr",     {28'h0, s_wr}, 32'h0000_0001);
        check("simul_s_rd",     {28'h0, s_rd}, 32'h0);
        tick();
        tick();
        tick();
        check("simul_hold",     m_rd_data, 32'h0000_0003);

        // Unmapped read
        m_addr = 32'hF000_0000; m_rd = 1'b1;
        tick();
        m_rd = 1'b0;
        check("unm_s_rd",       {28'h0, s_rd}, 32'h0);
        check("unm_s_wr",       {28'h0, s_wr}, 32'h0);
        tick();
        tick();
        check("unm_rd_data",    m_rd_data, 32'hBAD0_BAD0);
        check("unm_count1",     {16'h0, unmapped_count}, 32'h0000_0001);

        // Drive the counter up to saturation with continuous unmapped writes
        m_addr = 32'hF000_0000; m_wr = 1'b1;
        repeat (65533) tick();
        m_wr = 1'b0;
        check("sat_count_fffe", {16'h0, unmapped_count}, 32'h0000_FFFE);
        check("sat_no_s_wr",    {28'h0, s_wr}, 32'h0);
        m_wr = 1'b1;
        repeat (3) tick();
        m_wr = 1'b0;
        check("sat_count_ffff", {16'h0, unmapped_count}, 32'h0000_FFFF);
        tick();
        check("sat_count_hold", {16'h0, unmapped_count}, 32'h0000_FFFF);

        // Reset while a read is in flight
        m_addr = 32'h1000_0000; m_rd = 1'b1;
        tick();
        m_rd  = 1'b0;
        reset = 1'b1;
        check("mid_s_rd",       {28'h0, s_rd}, 32'h0000_0002);
        tick();
        reset = 1'b0;
        check("mid_rst_data",   m_rd_data, 32'h0);
        check("mid_rst_s_rd",   {28'h0, s_rd}, 32'h0);
        check("mid_rst_count",  {16'h0, unmapped_count}, 32'h0);
        tick();
        check("mid_no_late",    m_rd_data, 32'h0);
        check("mid_s_wr",       {28'h0, s_wr}, 32'h0);
        tick();
        check("mid_no_late2",   m_rd_data, 32'h0);
        check("mid_s_rd2",      {28'h0, s_rd}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
